pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The parameter XLEN SHALL default to 32 and set the PC and target width.
REQ-002 The parameter RESET_VEC SHALL default to 32'h0000_0000 and set the PC value loaded on reset.
REQ-003 The parameter BTB_DEPTH SHALL default to 8 and set the number of BTB entries; it SHALL be a power of two, 2..64.
REQ-004 The port clk SHALL be an input, 1 bit, and serve as the single clock; all state SHALL update on its rising edge.
REQ-005 The port rst SHALL be an input, 1 bit, and act as a synchronous, active-high reset.
REQ-006 The port stop SHALL be an input, 1 bit, and request that the PC be held (pipeline stall).
REQ-007 The port flush SHALL be an input, 1 bit, and request a redirect to din.
REQ-008 The port din SHALL be an input, XLEN bits, and carry the redirect target.
REQ-009 The port upd_valid SHALL be an input, 1 bit, and qualify a BTB update from the execute stage.
REQ-010 The ports upd_pc and upd_target SHALL be inputs, XLEN bits each, and carry the resolved branch PC and its target.
REQ-011 The port upd_taken SHALL be an input, 1 bit, and indicate that the resolved branch was taken.
REQ-012 The port pc SHALL be an output, XLEN bits, registered, and carry the current fetch PC.
REQ-013 The port pred_taken SHALL be an output, 1 bit, combinational from pc, and flag a BTB hit on the current pc.
REQ-014 The port misalign SHALL be an output, 1 bit, registered, and flag that the last accepted flush had din[1:0] != 0.

Function
REQ-015 The next-PC priority SHALL be: rst, then flush, then stop, then predicted/sequential; flush SHALL override stop.
REQ-016 On a flush, pc SHALL load {din[XLEN-1:2],2'b00} on the next edge, and misalign SHALL load (din[1:0]!=0).
REQ-017 On a stop without a flush, pc and misalign SHALL hold.
REQ-018 Otherwise pc SHALL load pred_taken ? btb_target : pc+4; misalign SHALL clear.
REQ-019 pc+4 SHALL be modulo 2^XLEN; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-020 Each BTB entry SHALL hold a valid bit, a tag pc[XLEN-1:IDX+2] and a target, where IDX = log2(BTB_DEPTH); the index SHALL be pc[IDX+1:2].
REQ-021 A hit SHALL require the indexed entry to be valid with a matching tag; pred_taken SHALL equal the hit.
REQ-022 When upd_valid=1 and upd_taken=1, the entry indexed by upd_pc SHALL be written with valid=1, tag and upd_target[XLEN-1:2],2'b00, replacing any previous content.
REQ-023 When upd_valid=1, upd_taken=0 and the indexed entry's tag matches upd_pc, that entry's valid bit SHALL clear; a non-matching entry SHALL be left unchanged.
REQ-024 BTB updates SHALL proceed regardless of stop and flush.
REQ-025 When a lookup and an update address the same entry in one cycle, the lookup SHALL use the pre-update contents; the write SHALL become visible on the following cycle.

Reset
REQ-026 While rst=1 at a rising edge, pc SHALL load RESET_VEC, misalign SHALL clear and all BTB valid bits SHALL clear; any flush, stop or upd_valid in that cycle SHALL be ignored.
REQ-027 BTB tag and target storage SHALL NOT require reset.
REQ-028 In the first cycle after reset deasserts, pc SHALL equal RESET_VEC and pred_taken SHALL be 0.

Configuration
REQ-029 With the macro PC_GEN_BTB_EN defined, the BTB SHALL be instantiated as specified in REQ-018 and REQ-020..025.
REQ-030 Without PC_GEN_BTB_EN, no BTB storage SHALL exist, pred_taken SHALL be constant 0, the upd_* inputs SHALL be ignored, and the non-flush, non-stop next PC SHALL be pc+4.

Verification
REQ-031 The bench SHALL cover reset then 3 free-running cycles: pc SHALL be 0x0, 0x4, 0x8, 0xC.
REQ-032 The bench SHALL cover stop=1 and flush=1 together with din=0x100: the next pc SHALL be 0x100 and misalign SHALL be 0.
REQ-033 The bench SHALL cover flush with din=0x203: the next pc SHALL be 0x200 and misalign SHALL be 1; on the following free cycle pc SHALL be 0x204 and misalign SHALL be 0.
REQ-034 The bench SHALL cover pc=0xFFFF_FFFC with no flush and no stop: the next pc SHALL be 0x0.
REQ-035 The bench SHALL cover (BTB_EN) an update with upd_pc=0x10, upd_target=0x80 and taken, then fetch reaching 0x10: pred_taken SHALL be 1 and the next pc SHALL be 0x80. A later not-taken update for 0x10 SHALL make the next visit to 0x10 go to 0x14.
REQ-036 The bench SHALL cover (BTB_EN) an update for upd_pc=0x30 with DEPTH=8, which aliases 0x10 with a different tag, while pc=0x10 in the same cycle: the lookup SHALL still hit the old target 0x80; on the next visit to 0x10, pred_taken SHALL be 0.

Source files
------------

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch PC generator control, redirect, BTB update and PC output bundle
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stop;
  logic            flush;
  logic [XLEN-1:0] din;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;
  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic            misalign;

  modport master (
    output stop, flush, din, upd_valid, upd_pc, upd_target, upd_taken,
    input  pc, pred_taken, misalign
  );

  modport slave (
    input  stop, flush, din, upd_valid, upd_pc, upd_target, upd_taken,
    output pc, pred_taken, misalign
  );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with optional direct-mapped BTB (enable with PC_GEN_BTB_EN)
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter int              BTB_DEPTH = 8
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            mis_q;
  logic            mis_d;
  logic            hit;
  logic [XLEN-1:0] pred_tgt;

`ifdef PC_GEN_BTB_EN
  localparam int IDX = $clog2(BTB_DEPTH);
  localparam int TW  = XLEN - IDX - 2;

  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TW-1:0]        btb_tag [BTB_DEPTH];
  logic [XLEN-3:0]      btb_tgt [BTB_DEPTH];

  logic [IDX-1:0] rd_idx;
  logic [IDX-1:0] wr_idx;
  logic [TW-1:0]  rd_tag;
  logic [TW-1:0]  wr_tag;
  logic           unused_low_bits;

  assign rd_idx = pc_q[IDX+1:2];
  assign rd_tag = pc_q[XLEN-1:IDX+2];
  assign wr_idx = bus.upd_pc[IDX+1:2];
  assign wr_tag = bus.upd_pc[XLEN-1:IDX+2];

  // Byte offsets of branch PC and target never reach the table
  assign unused_low_bits = ^{bus.upd_pc[1:0], bus.upd_target[1:0]};

  // Lookup reads the registered table, so a same-cycle write is seen next cycle
  assign hit      = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign pred_tgt = {btb_tgt[rd_idx], 2'b00};

  // Valid bits: cleared on reset, set by taken updates, dropped by matching not-taken updates
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (bus.upd_valid) begin
      if (bus.upd_taken) begin
        btb_valid[wr_idx] <= 1'b1;
      end else if (btb_tag[wr_idx] == wr_tag) begin
        btb_valid[wr_idx] <= 1'b0;
      end
    end
  end

  // Tag and target storage carry no reset; the valid bit guards stale contents
  always_ff @(posedge clk) begin
    if (!rst && bus.upd_valid && bus.upd_taken) begin
      btb_tag[wr_idx] <= wr_tag;
      btb_tgt[wr_idx] <= bus.upd_target[XLEN-1:2];
    end
  end
`else
  logic unused_upd;

  // Without the BTB the update port is accepted and dropped
  assign unused_upd = ^{bus.upd_valid, bus.upd_taken, bus.upd_pc, bus.upd_target};
  assign hit        = 1'b0;
  assign pred_tgt   = '0;
`endif

  // Next PC: flush beats stop, stop holds, otherwise predicted target or sequential
  always_comb begin
    pc_d  = pc_q + XLEN'(4);
    mis_d = 1'b0;
    if (bus.flush) begin
      pc_d  = {bus.din[XLEN-1:2], 2'b00};
      mis_d = |bus.din[1:0];
    end else if (bus.stop) begin
      pc_d  = pc_q;
      mis_d = mis_q;
    end else if (hit) begin
      pc_d = pred_tgt;
    end
  end

  // PC and misalign registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.misalign   = mis_q;
  assign bus.pred_taken = hit;

endmodule
